// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and sizing helpers for the SPI arbiter.
package spi_arb_pkg;
    localparam int NREQ_MAX = 8;

    typedef enum logic [2:0] {
        IDLE, SETUP, START, WAIT_BUSY, WAIT_DONE, READ, NEXT, RELEASE
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction
endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin picker; search starts one past ptr.
module spi_rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx
);
    logic [PW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        win = '0;
        win_idx = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                win = '0;
                win[idx] = 1'b1;
                win_idx = idx;
            end
        end
    end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_core among NREQ requesters,
// with per-requester slave selects and multi-byte transactions.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [DWIDTH-1:0]      rsp_data,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        ss_n,
    output logic                   busy,
    output logic                   core_cs,
    output logic                   core_wr,
    output logic                   core_rd,
    output logic [DWIDTH-1:0]      core_din,
    input  logic [DWIDTH-1:0]      core_dout,
    input  logic                   core_done
);
    localparam int PW = clog2(NREQ);

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, g, win_idx;
    logic [NREQ-1:0] win;
    logic            last_r;

    spi_rr_pick #(.NREQ(NREQ)) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .win_idx(win_idx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (|req) state_nx = SETUP;
            SETUP:     state_nx = START;
            START:     if (core_done) state_nx = WAIT_BUSY;
            WAIT_BUSY: if (!core_done) state_nx = WAIT_DONE;
            WAIT_DONE: if (core_done) state_nx = READ;
            READ:      state_nx = last_r ? RELEASE : NEXT;
            NEXT:      state_nx = req[g] ? START : RELEASE;
            RELEASE:   state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Strobes are registered on the transition edge, so each is high for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= PW'(NREQ - 1);
            g        <= '0;
            last_r   <= 1'b0;
            grant    <= '0;
            ss_n     <= '1;
            ack      <= '0;
            rsp_data <= '0;
            busy     <= 1'b0;
            core_cs  <= 1'b0;
            core_wr  <= 1'b0;
            core_rd  <= 1'b0;
            core_din <= '0;
        end else begin
            state   <= state_nx;
            busy    <= state_nx != IDLE;
            ack     <= '0;
            core_cs <= 1'b0;
            core_wr <= 1'b0;
            core_rd <= 1'b0;
            if (state == IDLE && |req) begin
                grant <= win;
                ss_n  <= ~win;
                g     <= win_idx;
            end
            if (state == START && core_done) begin
                core_cs  <= 1'b1;
                core_wr  <= 1'b1;
                core_din <= req_data[g*DWIDTH +: DWIDTH];
                last_r   <= req_last[g];
            end
            if (state == WAIT_DONE && core_done) begin
                core_cs <= 1'b1;
                core_rd <= 1'b1;
            end
            if (state == READ) begin
                rsp_data <= core_dout;
                ack      <= grant;
            end
            if (state == RELEASE) begin
                grant <= '0;
                ss_n  <= '1;
                ptr   <= g;
            end
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench with a behavioral spi_core plus shift-register loopback.
module tb_spi_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack, grant, ss_n;
    logic [7:0]  rsp_data, core_din;
    logic        busy, core_cs, core_wr, core_rd, core_done;
    logic [7:0]  core_dout = 8'h00;

    int checks = 0;
    int failures = 0;

    // Core model: a write drops done for 8 cycles, then returns the old shreg byte.
    logic       mdone = 1'b1;
    logic       hold = 1'b0;
    int         mcnt = 0;
    logic [7:0] shreg = 8'h3C;
    logic [7:0] tx = 8'h00;

    assign core_done = mdone & ~hold;

    always @(posedge clk) begin
        if (core_cs && core_wr) begin
            tx    <= core_din;
            mdone <= 1'b0;
            mcnt  <= 8;
        end else if (!mdone) begin
            if (mcnt == 1) begin
                mdone     <= 1'b1;
                core_dout <= shreg;
                shreg     <= tx;
            end
            mcnt <= mcnt - 1;
        end
    end

    always #5 clk = ~clk;

    spi_arbiter #(.NREQ(4), .DWIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_last(req_last),
        .req_data(req_data),
        .ack(ack),
        .rsp_data(rsp_data),
        .grant(grant),
        .ss_n(ss_n),
        .busy(busy),
        .core_cs(core_cs),
        .core_wr(core_wr),
        .core_rd(core_rd),
        .core_din(core_din),
        .core_dout(core_dout),
        .core_done(core_done)
    );

    int         overlap_err = 0;
    int         stray_ack = 0;
    int         ss_err = 0;
    int         rdwr_err = 0;
    logic [3:0] prev_grant = '0;

    always @(negedge clk) begin
        if (prev_grant != 0 && grant != 0 && grant != prev_grant) overlap_err++;
        if ((ack & ~grant) != 0) stray_ack++;
        if (ss_n !== ~grant) ss_err++;
        if (core_wr && core_rd) rdwr_err++;
        prev_grant = grant;
    end

    task automatic wait_ack(output logic [3:0] a);
        a = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                a = ack;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (ss_n !== 4'b1111) begin failures++; $display("FAIL reset_ss_n: got %b want 1111", ss_n); end
        checks++; if ({busy, core_cs, core_wr, core_rd} !== 4'b0000) begin failures++; $display("FAIL reset_strobes: got %b want 0000", {busy, core_cs, core_wr, core_rd}); end
        checks++; if ({ack, rsp_data, core_din} !== 20'h0) begin failures++; $display("FAIL reset_data: got %h want 00000", {ack, rsp_data, core_din}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int wrs;
        logic [3:0] a;
        wrs = 0;
        a = '0;
        req = 4'b0100;
        req_data[16 +: 8] = 8'hA5;
        req_last = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b want 0100", grant); end
        checks++; if (ss_n !== 4'b1011) begin failures++; $display("FAIL single_ss_n: got %b want 1011", ss_n); end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (core_wr) begin
                wrs++;
                checks++; if (core_din !== 8'hA5) begin failures++; $display("FAIL single_din: got %h want a5", core_din); end
            end
            if (ack != 0) begin
                a = ack;
                break;
            end
        end
        checks++; if (a !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b want 0100", a); end
        checks++; if (rsp_data !== 8'h3C) begin failures++; $display("FAIL single_rsp: got %h want 3c", rsp_data); end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (wrs !== 1) begin failures++; $display("FAIL single_wr_count: got %0d want 1", wrs); end
        checks++; if ({ss_n, busy} !== 5'b11110) begin failures++; $display("FAIL single_idle: got %b want 11110", {ss_n, busy}); end
    endtask

    task automatic test_round_robin();
        logic [3:0] a;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_r [5] = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13};
        do_reset();
        req_data = 32'h13121110;
        req_last = 4'b1111;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack(a);
            checks++; if (a !== exp_g[n]) begin failures++; $display("FAIL rr_order[%0d]: got %b want %b", n, a, exp_g[n]); end
            checks++; if (rsp_data !== exp_r[n]) begin failures++; $display("FAIL rr_rsp[%0d]: got %h want %h", n, rsp_data, exp_r[n]); end
            if (n == 4) req = '0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_burst();
        int acks, wrs, ss_hi, t_ack1, t_wr2;
        logic granted;
        acks = 0; wrs = 0; ss_hi = 0; t_ack1 = 0; t_wr2 = 0; granted = 1'b0;
        req_data[8 +: 8] = 8'h11;
        req_last = 4'b0000;
        req = 4'b0010;
        for (int i = 0; i < 400 && acks < 3; i++) begin
            @(negedge clk);
            if (grant[1]) granted = 1'b1;
            if (granted && ss_n[1]) ss_hi++;
            if (core_wr) begin
                wrs++;
                if (wrs == 2) t_wr2 = i;
            end
            if (ack != 0) begin
                acks++;
                checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL burst_ack: got %b want 0010", ack); end
                if (acks == 1) begin
                    t_ack1 = i;
                    checks++; if (rsp_data !== 8'h10) begin failures++; $display("FAIL burst_rsp1: got %h want 10", rsp_data); end
                    req_data[8 +: 8] = 8'h22;
                end else if (acks == 2) begin
                    req_data[8 +: 8] = 8'h33;
                    req_last = 4'b0010;
                end else begin
                    checks++; if (rsp_data !== 8'h22) begin failures++; $display("FAIL burst_rsp3: got %h want 22", rsp_data); end
                    req = '0;
                end
            end
        end
        checks++; if (acks !== 3) begin failures++; $display("FAIL burst_ack_count: got %0d want 3", acks); end
        checks++; if (wrs !== 3) begin failures++; $display("FAIL burst_wr_count: got %0d want 3", wrs); end
        checks++; if (ss_hi !== 0) begin failures++; $display("FAIL burst_ss_held: got %0d high cycles want 0", ss_hi); end
        checks++; if (t_wr2 - t_ack1 !== 2) begin failures++; $display("FAIL burst_gap: got %0d want 2", t_wr2 - t_ack1); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_abandon();
        logic [3:0] a;
        a = '0;
        req_data = 32'h5AB2B100;
        req_last = 4'b0110;
        req = 4'b1000;
        for (int i = 0; i < 20 && grant !== 4'b1000; i++) @(negedge clk);
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL abandon_grant3: got %b want 1000", grant); end
        req = 4'b1110;
        wait_ack(a);
        checks++; if (a !== 4'b1000) begin failures++; $display("FAIL abandon_ack: got %b want 1000", a); end
        checks++; if (rsp_data !== 8'h33) begin failures++; $display("FAIL abandon_rsp: got %h want 33", rsp_data); end
        req = 4'b0110;
        @(negedge clk);
        checks++; if ({grant, ack} !== 8'b1000_0000) begin failures++; $display("FAIL abandon_release: got %b want 10000000", {grant, ack}); end
        @(negedge clk);
        checks++; if ({grant, ss_n} !== 8'b0000_1111) begin failures++; $display("FAIL abandon_idle: got %b want 00001111", {grant, ss_n}); end
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL abandon_next: got %b want 0010", grant); end
        wait_ack(a);
        checks++; if ({a, rsp_data} !== {4'b0010, 8'h5A}) begin failures++; $display("FAIL abandon_r1: got %h want 25a", {a, rsp_data}); end
        req = 4'b0100;
        wait_ack(a);
        checks++; if ({a, rsp_data} !== {4'b0100, 8'hB1}) begin failures++; $display("FAIL abandon_r2: got %h want 4b1", {a, rsp_data}); end
        req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] a, gfirst;
        logic prev_done, wr_seen;
        int wr_low;
        a = '0; gfirst = '0; prev_done = 1'b0; wr_seen = 1'b0; wr_low = 0;
        req_data = 32'h00007700;
        req_last = 4'b0010;
        req = 4'b0010;
        for (int i = 0; i < 40 && !core_wr; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({grant, ss_n, busy} !== 9'b0000_1111_0) begin failures++; $display("FAIL rstmid_sel: got %b want 000011110", {grant, ss_n, busy}); end
        checks++; if ({core_cs, core_wr, core_rd, ack} !== 7'b0) begin failures++; $display("FAIL rstmid_strobes: got %b want 0000000", {core_cs, core_wr, core_rd, ack}); end
        checks++; if ({rsp_data, core_din} !== 16'h0) begin failures++; $display("FAIL rstmid_data: got %h want 0000", {rsp_data, core_din}); end
        req = 4'b0001;
        req_data = 32'h00000099;
        req_last = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gfirst == 0 && grant != 0) gfirst = grant;
            if (core_wr) begin
                wr_seen = 1'b1;
                if (!prev_done) wr_low++;
            end
            if (ack != 0) begin
                a = ack;
                break;
            end
            prev_done = core_done;
        end
        checks++; if (gfirst !== 4'b0001) begin failures++; $display("FAIL rstmid_grant: got %b want 0001", gfirst); end
        checks++; if ({wr_seen, wr_low} !== {1'b1, 32'd0}) begin failures++; $display("FAIL rstmid_wr_wait: got seen=%b early=%0d want seen=1 early=0", wr_seen, wr_low); end
        checks++; if ({a, rsp_data} !== {4'b0001, 8'h77}) begin failures++; $display("FAIL rstmid_ack: got %h want 177", {a, rsp_data}); end
        req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_contention();
        int wrs;
        logic [3:0] a;
        wrs = 0;
        a = '0;
        hold = 1'b1;
        req_data = 32'h00C30000;
        req_last = 4'b0100;
        req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (core_wr) wrs++;
        end
        checks++; if (wrs !== 0) begin failures++; $display("FAIL cont_no_wr: got %0d want 0", wrs); end
        checks++; if ({grant, busy} !== 5'b0100_1) begin failures++; $display("FAIL cont_grant: got %b want 01001", {grant, busy}); end
        hold = 1'b0;
        @(negedge clk);
        checks++; if ({core_wr, core_din} !== {1'b1, 8'hC3}) begin failures++; $display("FAIL cont_wr_after: got %h want 1c3", {core_wr, core_din}); end
        wait_ack(a);
        checks++; if ({a, rsp_data} !== {4'b0100, 8'h99}) begin failures++; $display("FAIL cont_ack: got %h want 499", {a, rsp_data}); end
        req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_abandon();
        test_reset_mid();
        test_contention();
        @(negedge clk);
        checks++; if (overlap_err !== 0) begin failures++; $display("FAIL ss_gap: got %0d overlaps want 0", overlap_err); end
        checks++; if (stray_ack !== 0) begin failures++; $display("FAIL stray_ack: got %0d want 0", stray_ack); end
        checks++; if (ss_err !== 0) begin failures++; $display("FAIL ss_vs_grant: got %0d want 0", ss_err); end
        checks++; if (rdwr_err !== 0) begin failures++; $display("FAIL wr_rd_both: got %0d want 0", rdwr_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
